// File: rtl/rs_multi_issue.sv
// Multi-issue reservation station: DEPTH entries, NUM_CDB wakeup buses, one issue per FU per cycle.
// Optional macro RS_AGE_SELECT_EN: oldest-first select via an age matrix; otherwise lowest-index select.
module rs_multi_issue #(
    parameter int unsigned PREG_WIDTH = 6,
    parameter int unsigned ROB_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NUM_FU     = 3,
    parameter int unsigned NUM_CDB    = 2,
    localparam int unsigned FU_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic                            i_disp_valid,
    output logic                            o_disp_ready,
    input  logic [6:0]                      i_disp_opcode,
    input  logic [2:0]                      i_disp_funct3,
    input  logic [6:0]                      i_disp_csigs,
    input  logic [DATA_WIDTH-1:0]           i_disp_imm,
    input  logic [PREG_WIDTH-1:0]           i_disp_rd,
    input  logic [PREG_WIDTH-1:0]           i_disp_src1,
    input  logic [PREG_WIDTH-1:0]           i_disp_src2,
    input  logic [DATA_WIDTH-1:0]           i_disp_data1,
    input  logic [DATA_WIDTH-1:0]           i_disp_data2,
    input  logic                            i_disp_rdy1,
    input  logic                            i_disp_rdy2,
    input  logic [FU_W-1:0]                 i_disp_fu,
    input  logic [ROB_WIDTH-1:0]            i_disp_rob,
    input  logic [NUM_CDB-1:0]              i_cdb_valid,
    input  logic [NUM_CDB*PREG_WIDTH-1:0]   i_cdb_tag,
    input  logic [NUM_CDB*DATA_WIDTH-1:0]   i_cdb_data,
    input  logic [NUM_FU-1:0]               i_fu_ready,
    output logic [NUM_FU-1:0]               o_iss_valid,
    output logic [NUM_FU*7-1:0]             o_iss_opcode,
    output logic [NUM_FU*3-1:0]             o_iss_funct3,
    output logic [NUM_FU*7-1:0]             o_iss_csigs,
    output logic [NUM_FU*DATA_WIDTH-1:0]    o_iss_imm,
    output logic [NUM_FU*PREG_WIDTH-1:0]    o_iss_rd,
    output logic [NUM_FU*DATA_WIDTH-1:0]    o_iss_data1,
    output logic [NUM_FU*DATA_WIDTH-1:0]    o_iss_data2,
    output logic [NUM_FU*ROB_WIDTH-1:0]     o_iss_rob,
    output logic [CNT_W-1:0]                o_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Entry state
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_rdy1;
    logic [DEPTH-1:0]      r_rdy2;
    logic [6:0]            r_opcode [DEPTH];
    logic [2:0]            r_funct3 [DEPTH];
    logic [6:0]            r_csigs  [DEPTH];
    logic [DATA_WIDTH-1:0] r_imm    [DEPTH];
    logic [PREG_WIDTH-1:0] r_rd     [DEPTH];
    logic [PREG_WIDTH-1:0] r_src1   [DEPTH];
    logic [PREG_WIDTH-1:0] r_src2   [DEPTH];
    logic [DATA_WIDTH-1:0] r_data1  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data2  [DEPTH];
    logic [FU_W-1:0]       r_fu     [DEPTH];
    logic [ROB_WIDTH-1:0]  r_rob    [DEPTH];

    logic [CNT_W-1:0]      r_count;
    logic                  r_disp_ready;

    logic [NUM_FU-1:0]            r_iss_valid;
    logic [NUM_FU*7-1:0]          r_iss_opcode;
    logic [NUM_FU*3-1:0]          r_iss_funct3;
    logic [NUM_FU*7-1:0]          r_iss_csigs;
    logic [NUM_FU*DATA_WIDTH-1:0] r_iss_imm;
    logic [NUM_FU*PREG_WIDTH-1:0] r_iss_rd;
    logic [NUM_FU*DATA_WIDTH-1:0] r_iss_data1;
    logic [NUM_FU*DATA_WIDTH-1:0] r_iss_data2;
    logic [NUM_FU*ROB_WIDTH-1:0]  r_iss_rob;

    logic [IDX_W-1:0]      w_free_idx;
    logic                  w_free_found;
    logic                  w_disp_accept;
    logic [DEPTH-1:0]      w_disp_mask;
    logic                  w_disp_rdy1;
    logic                  w_disp_rdy2;
    logic [DATA_WIDTH-1:0] w_disp_data1;
    logic [DATA_WIDTH-1:0] w_disp_data2;
    logic [DEPTH-1:0]      w_wake1;
    logic [DEPTH-1:0]      w_wake2;
    logic [DATA_WIDTH-1:0] w_wdata1 [DEPTH];
    logic [DATA_WIDTH-1:0] w_wdata2 [DEPTH];
    logic [DEPTH-1:0]      w_elig   [NUM_FU];
    logic [DEPTH-1:0]      w_cand   [NUM_FU];
    logic [IDX_W-1:0]      w_sel_idx [NUM_FU];
    logic [NUM_FU-1:0]     w_sel_found;
    logic [DEPTH-1:0]      w_issue_mask;
    logic [CNT_W-1:0]      w_iss_cnt;
    logic [CNT_W-1:0]      w_count_next;

    // Lowest-index free slot from registered occupancy; slots issuing this cycle stay busy.
    always_comb begin
        w_free_idx   = '0;
        w_free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_valid[i] && !w_free_found) begin
                w_free_idx   = IDX_W'(i);
                w_free_found = 1'b1;
            end
        end
    end

    assign w_disp_accept = i_disp_valid & r_disp_ready & w_free_found;
    assign w_disp_mask   = w_disp_accept ? (DEPTH'(1) << w_free_idx) : '0;

    // Dispatch bypass; scanning downward leaves the lowest matching bus in place.
    always_comb begin
        w_disp_rdy1  = i_disp_rdy1;
        w_disp_rdy2  = i_disp_rdy2;
        w_disp_data1 = i_disp_data1;
        w_disp_data2 = i_disp_data2;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (i_cdb_valid[k] && !i_disp_rdy1 &&
                i_cdb_tag[k*PREG_WIDTH +: PREG_WIDTH] == i_disp_src1) begin
                w_disp_rdy1  = 1'b1;
                w_disp_data1 = i_cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (i_cdb_valid[k] && !i_disp_rdy2 &&
                i_cdb_tag[k*PREG_WIDTH +: PREG_WIDTH] == i_disp_src2) begin
                w_disp_rdy2  = 1'b1;
                w_disp_data2 = i_cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // CDB wakeup for waiting sources of valid entries
    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wdata1[i] = '0;
            w_wdata2[i] = '0;
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (i_cdb_valid[k] && r_valid[i] && !r_rdy1[i] &&
                    i_cdb_tag[k*PREG_WIDTH +: PREG_WIDTH] == r_src1[i]) begin
                    w_wake1[i]  = 1'b1;
                    w_wdata1[i] = i_cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
                if (i_cdb_valid[k] && r_valid[i] && !r_rdy2[i] &&
                    i_cdb_tag[k*PREG_WIDTH +: PREG_WIDTH] == r_src2[i]) begin
                    w_wake2[i]  = 1'b1;
                    w_wdata2[i] = i_cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_elig[f][i] = r_valid[i] & r_rdy1[i] & r_rdy2[i] &
                               (r_fu[i] == FU_W'(f)) & i_fu_ready[f];
            end
        end
    end

`ifdef RS_AGE_SELECT_EN
    // older[j][i] set means entry j was dispatched before entry i
    logic [DEPTH-1:0] r_older [DEPTH];

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic blk;
                blk = 1'b0;
                for (int j = 0; j < DEPTH; j++) begin
                    blk = blk | (w_elig[f][j] & r_older[j][i]);
                end
                w_cand[f][i] = w_elig[f][i] & ~blk;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_older[i] <= '0;
            end
        end else if (!i_flush && w_disp_accept) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_older[j][w_free_idx] <= r_valid[j];
                r_older[w_free_idx][j] <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            w_cand[f] = w_elig[f];
        end
    end
`endif

    // Per-FU pick: lowest index among candidates (unique when age select is enabled)
    always_comb begin
        w_sel_found  = '0;
        w_issue_mask = '0;
        w_iss_cnt    = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            w_sel_idx[f] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cand[f][i] && !w_sel_found[f]) begin
                    w_sel_idx[f]    = IDX_W'(i);
                    w_sel_found[f]  = 1'b1;
                    w_issue_mask[i] = 1'b1;
                end
            end
            w_iss_cnt = w_iss_cnt + CNT_W'(w_sel_found[f]);
        end
    end

    assign w_count_next = r_count + CNT_W'(w_disp_accept) - w_iss_cnt;

    // Control state: occupancy, readiness, count and issue valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid      <= '0;
            r_rdy1       <= '0;
            r_rdy2       <= '0;
            r_count      <= '0;
            r_disp_ready <= 1'b1;
            r_iss_valid  <= '0;
        end else if (i_flush) begin
            r_valid      <= '0;
            r_count      <= '0;
            r_disp_ready <= 1'b1;
            r_iss_valid  <= '0;
        end else begin
            r_valid      <= (r_valid & ~w_issue_mask) | w_disp_mask;
            r_rdy1       <= r_rdy1 | w_wake1;
            r_rdy2       <= r_rdy2 | w_wake2;
            if (w_disp_accept) begin
                r_rdy1[w_free_idx] <= w_disp_rdy1;
                r_rdy2[w_free_idx] <= w_disp_rdy2;
            end
            r_count      <= w_count_next;
            r_disp_ready <= (w_count_next < CNT_W'(DEPTH));
            r_iss_valid  <= w_sel_found;
        end
    end

    // Entry payload and captured operands
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wake1[i]) r_data1[i] <= w_wdata1[i];
                if (w_wake2[i]) r_data2[i] <= w_wdata2[i];
            end
            if (w_disp_accept) begin
                r_opcode[w_free_idx] <= i_disp_opcode;
                r_funct3[w_free_idx] <= i_disp_funct3;
                r_csigs[w_free_idx]  <= i_disp_csigs;
                r_imm[w_free_idx]    <= i_disp_imm;
                r_rd[w_free_idx]     <= i_disp_rd;
                r_src1[w_free_idx]   <= i_disp_src1;
                r_src2[w_free_idx]   <= i_disp_src2;
                r_data1[w_free_idx]  <= w_disp_data1;
                r_data2[w_free_idx]  <= w_disp_data2;
                r_fu[w_free_idx]     <= i_disp_fu;
                r_rob[w_free_idx]    <= i_disp_rob;
            end
        end
    end

    // Issue payload registers; they hold their last value between issues
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_iss_opcode <= '0;
            r_iss_funct3 <= '0;
            r_iss_csigs  <= '0;
            r_iss_imm    <= '0;
            r_iss_rd     <= '0;
            r_iss_data1  <= '0;
            r_iss_data2  <= '0;
            r_iss_rob    <= '0;
        end else if (!i_flush) begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (w_sel_found[f]) begin
                    r_iss_opcode[f*7 +: 7]                   <= r_opcode[w_sel_idx[f]];
                    r_iss_funct3[f*3 +: 3]                   <= r_funct3[w_sel_idx[f]];
                    r_iss_csigs[f*7 +: 7]                    <= r_csigs[w_sel_idx[f]];
                    r_iss_imm[f*DATA_WIDTH +: DATA_WIDTH]    <= r_imm[w_sel_idx[f]];
                    r_iss_rd[f*PREG_WIDTH +: PREG_WIDTH]     <= r_rd[w_sel_idx[f]];
                    r_iss_data1[f*DATA_WIDTH +: DATA_WIDTH]  <= r_data1[w_sel_idx[f]];
                    r_iss_data2[f*DATA_WIDTH +: DATA_WIDTH]  <= r_data2[w_sel_idx[f]];
                    r_iss_rob[f*ROB_WIDTH +: ROB_WIDTH]      <= r_rob[w_sel_idx[f]];
                end
            end
        end
    end

    assign o_disp_ready = r_disp_ready;
    assign o_count      = r_count;
    assign o_iss_valid  = r_iss_valid;
    assign o_iss_opcode = r_iss_opcode;
    assign o_iss_funct3 = r_iss_funct3;
    assign o_iss_csigs  = r_iss_csigs;
    assign o_iss_imm    = r_iss_imm;
    assign o_iss_rd     = r_iss_rd;
    assign o_iss_data1  = r_iss_data1;
    assign o_iss_data2  = r_iss_data2;
    assign o_iss_rob    = r_iss_rob;

endmodule

// File: tb/tb_rs_multi_issue.sv
// Scoreboard bench for rs_multi_issue: queue-based reference model predicts every issue and its cycle.
module tb_rs_multi_issue;
    localparam int P = 6, R = 6, D = 32, DEPTH = 16, NFU = 3, NCDB = 2, FU_W = 2, CNT_W = 5;

    logic clk, rst, flush, disp_valid, disp_ready;
    logic [6:0] disp_opcode, disp_csigs;
    logic [2:0] disp_funct3;
    logic [D-1:0] disp_imm, disp_data1, disp_data2;
    logic [P-1:0] disp_rd, disp_src1, disp_src2;
    logic disp_rdy1, disp_rdy2;
    logic [FU_W-1:0] disp_fu;
    logic [R-1:0] disp_rob;
    logic [NCDB-1:0] cdb_valid;
    logic [NCDB*P-1:0] cdb_tag;
    logic [NCDB*D-1:0] cdb_data;
    logic [NFU-1:0] fu_ready, iss_valid;
    logic [NFU*7-1:0] iss_opcode, iss_csigs;
    logic [NFU*3-1:0] iss_funct3;
    logic [NFU*D-1:0] iss_imm, iss_data1, iss_data2;
    logic [NFU*P-1:0] iss_rd;
    logic [NFU*R-1:0] iss_rob;
    logic [CNT_W-1:0] count;

    rs_multi_issue dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_disp_valid(disp_valid), .o_disp_ready(disp_ready),
        .i_disp_opcode(disp_opcode), .i_disp_funct3(disp_funct3), .i_disp_csigs(disp_csigs),
        .i_disp_imm(disp_imm), .i_disp_rd(disp_rd), .i_disp_src1(disp_src1), .i_disp_src2(disp_src2),
        .i_disp_data1(disp_data1), .i_disp_data2(disp_data2), .i_disp_rdy1(disp_rdy1), .i_disp_rdy2(disp_rdy2),
        .i_disp_fu(disp_fu), .i_disp_rob(disp_rob), .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag),
        .i_cdb_data(cdb_data), .i_fu_ready(fu_ready), .o_iss_valid(iss_valid), .o_iss_opcode(iss_opcode),
        .o_iss_funct3(iss_funct3), .o_iss_csigs(iss_csigs), .o_iss_imm(iss_imm), .o_iss_rd(iss_rd),
        .o_iss_data1(iss_data1), .o_iss_data2(iss_data2), .o_iss_rob(iss_rob), .o_count(count)
    );

    typedef struct {
        logic [6:0] opc; logic [2:0] f3; logic [6:0] cs; logic [31:0] imm;
        logic [5:0] rd, s1, s2, rob; logic [31:0] d1, d2;
        bit r1, r2; int fu; int seq; int slot;
    } op_t;
    typedef struct { int cyc; logic [124:0] pl; } exp_t;

    op_t  m_ops[$];
    exp_t exp_q[NFU][$];
    int cyc = 0, errors = 0, checks = 0, next_seq = 0, next_rob = 0;
    bit started = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [124:0] payload(op_t o);
        return {o.opc, o.f3, o.cs, o.imm, o.rd, o.d1, o.d2, o.rob};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cdb_lookup(input logic [5:0] tag, output bit hit, output logic [31:0] data);
        hit = 0; data = '0;
        for (int k = 0; k < NCDB; k++) begin
            if (!hit && cdb_valid[k] && cdb_tag[k*P +: P] == tag) begin
                hit = 1; data = cdb_data[k*D +: D];
            end
        end
    endtask

    // Reference model: one call per rising edge, using the inputs held across that edge.
    task automatic model_edge();
        op_t keep[$];
        op_t n;
        int sel[NFU];
        bit hit, used, is_sel;
        logic [31:0] d;
        if (rst || flush) begin
            m_ops.delete();
            return;
        end
        for (int f = 0; f < NFU; f++) begin
            sel[f] = -1;
            if (fu_ready[f]) begin
                for (int i = 0; i < m_ops.size(); i++) begin
                    if (m_ops[i].r1 && m_ops[i].r2 && m_ops[i].fu == f) begin
`ifdef RS_AGE_SELECT_EN
                        if (sel[f] < 0 || m_ops[i].seq < m_ops[sel[f]].seq) sel[f] = i;
`else
                        if (sel[f] < 0 || m_ops[i].slot < m_ops[sel[f]].slot) sel[f] = i;
`endif
                    end
                end
                if (sel[f] >= 0) exp_q[f].push_back('{cyc + 1, payload(m_ops[sel[f]])});
            end
        end
        for (int i = 0; i < m_ops.size(); i++) begin
            if (!m_ops[i].r1) begin
                cdb_lookup(m_ops[i].s1, hit, d);
                if (hit) begin m_ops[i].r1 = 1; m_ops[i].d1 = d; end
            end
            if (!m_ops[i].r2) begin
                cdb_lookup(m_ops[i].s2, hit, d);
                if (hit) begin m_ops[i].r2 = 1; m_ops[i].d2 = d; end
            end
        end
        for (int i = 0; i < m_ops.size(); i++) begin
            is_sel = 0;
            for (int f = 0; f < NFU; f++) if (sel[f] == i) is_sel = 1;
            if (!is_sel) keep.push_back(m_ops[i]);
        end
        if (disp_valid && m_ops.size() < DEPTH) begin
            n.slot = -1;
            for (int s = 0; s < DEPTH && n.slot < 0; s++) begin
                used = 0;
                foreach (m_ops[i]) if (m_ops[i].slot == s) used = 1;
                if (!used) n.slot = s;
            end
            n.opc = disp_opcode; n.f3 = disp_funct3; n.cs = disp_csigs; n.imm = disp_imm;
            n.rd = disp_rd; n.s1 = disp_src1; n.s2 = disp_src2; n.rob = disp_rob;
            n.fu = int'(disp_fu); n.seq = next_seq++;
            n.r1 = disp_rdy1; n.d1 = disp_data1; n.r2 = disp_rdy2; n.d2 = disp_data2;
            if (!n.r1) begin cdb_lookup(n.s1, hit, d); if (hit) begin n.r1 = 1; n.d1 = d; end end
            if (!n.r2) begin cdb_lookup(n.s2, hit, d); if (hit) begin n.r2 = 1; n.d2 = d; end end
            keep.push_back(n);
        end
        m_ops = keep;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    // Monitor: pops the expected issue for every presented iss_valid and checks occupancy.
    always @(negedge clk) begin
        if (started) begin
            for (int f = 0; f < NFU; f++) begin
                while (exp_q[f].size() > 0 && exp_q[f][0].cyc < cyc) begin
                    checks++; errors++;
                    $display("FAIL missed_issue fu%0d: got none expected issue at cycle %0d", f, exp_q[f][0].cyc);
                    void'(exp_q[f].pop_front());
                end
                if (iss_valid[f]) begin
                    if (exp_q[f].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_issue fu%0d: got rob %0h expected no issue (cycle %0d)",
                                 f, iss_rob[f*R +: R], cyc);
                    end else begin
                        exp_t e;
                        e = exp_q[f].pop_front();
                        check($sformatf("issue_cycle_fu%0d", f), 128'(cyc), 128'(e.cyc));
                        check($sformatf("issue_payload_fu%0d", f),
                              128'({iss_opcode[f*7 +: 7], iss_funct3[f*3 +: 3], iss_csigs[f*7 +: 7],
                                    iss_imm[f*D +: D], iss_rd[f*P +: P], iss_data1[f*D +: D],
                                    iss_data2[f*D +: D], iss_rob[f*R +: R]}), 128'(e.pl));
                    end
                end
            end
            check("count", 128'(count), 128'(m_ops.size()));
            check("disp_ready", 128'(disp_ready), 128'(m_ops.size() < DEPTH));
        end
    end

    task automatic idle();
        disp_valid = 0; cdb_valid = '0; flush = 0; rst = 0;
    endtask

    task automatic disp(int fu, bit r1, bit r2, logic [5:0] s1, logic [5:0] s2);
        disp_valid = 1;
        disp_opcode = 7'($urandom); disp_funct3 = 3'($urandom); disp_csigs = 7'($urandom);
        disp_imm = $urandom; disp_rd = 6'($urandom);
        disp_src1 = s1; disp_src2 = s2; disp_rdy1 = r1; disp_rdy2 = r2;
        disp_data1 = $urandom; disp_data2 = $urandom;
        disp_fu = 2'(fu); disp_rob = 6'(next_rob); next_rob++;
    endtask

    initial begin
        bit done;
        rst = 1; flush = 0; disp_valid = 0; fu_ready = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        disp_opcode = '0; disp_funct3 = '0; disp_csigs = '0; disp_imm = '0; disp_rd = '0;
        disp_src1 = '0; disp_src2 = '0; disp_data1 = '0; disp_data2 = '0;
        disp_rdy1 = 0; disp_rdy2 = 0; disp_fu = '0; disp_rob = '0;
        step(); started = 1; step();
        check("rst_count", 128'(count), 128'(0));
        check("rst_disp_ready", 128'(disp_ready), 128'(1));
        check("rst_iss_valid", 128'(iss_valid), 128'(0));
        idle();

        // Fill to capacity, then drain one per cycle through FU0
        for (int i = 0; i < 16; i++) begin disp(0, 1, 1, 6'd0, 6'd0); step(); end
        disp(0, 1, 1, 6'd0, 6'd0); step();
        check("full_count", 128'(count), 128'(16));
        check("full_disp_ready", 128'(disp_ready), 128'(0));
        idle(); fu_ready = 3'b001;
        for (int i = 0; i < 18; i++) step();
        check("drained_count", 128'(count), 128'(0));

        // CDB wakeup: no same-cycle wakeup-to-issue
        fu_ready = 3'b111;
        disp(1, 0, 1, 6'd5, 6'd0); step(); idle();
        step(); step();
        cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd5}; cdb_data = {32'h0, 32'hDEADBEEF}; step(); idle();
        check("wake_not_same_cycle", 128'(iss_valid[1]), 128'(0));
        step();
        check("wake_issue", 128'(iss_valid[1]), 128'(1));
        check("wake_data1", 128'(iss_data1[1*D +: D]), 128'(32'hDEADBEEF));

        // Dispatch bypass on bus 1
        disp(0, 1, 0, 6'd0, 6'd9);
        cdb_valid = 2'b10; cdb_tag = {6'd9, 6'd3}; cdb_data = {32'h1234, 32'h5555}; step(); idle();
        step();
        check("bypass_issue", 128'(iss_valid[0]), 128'(1));
        check("bypass_data2", 128'(iss_data2[0 +: D]), 128'(32'h1234));

        // Age vs. index ordering after slot reuse
        fu_ready = '0;
        disp(0, 0, 1, 6'd7, 6'd0); step();
        disp(0, 1, 1, 6'd0, 6'd0); step();
        disp(0, 1, 1, 6'd0, 6'd0); step();
        disp(0, 0, 1, 6'd7, 6'd0); step(); idle();
        fu_ready = 3'b001; step(); step();
        disp(0, 0, 1, 6'd7, 6'd0); step();
        disp(0, 0, 1, 6'd7, 6'd0); step(); idle();
        cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd7}; cdb_data = {32'h0, 32'hA5A5A5A5}; step(); idle();
        for (int i = 0; i < 6; i++) step();

        // Parallel issue across FUs
        fu_ready = '0;
        for (int f = 0; f < 3; f++) begin disp(f, 1, 1, 6'd0, 6'd0); step(); end
        idle(); fu_ready = 3'b111; step();
        check("par_issue_all", 128'(iss_valid), 128'(3'b111));
        fu_ready = '0;
        for (int f = 0; f < 3; f++) begin disp(f, 1, 1, 6'd0, 6'd0); step(); end
        idle(); fu_ready = 3'b011; step();
        check("par_issue_fu2_blocked", 128'(iss_valid), 128'(3'b011));
        step();
        check("par_fu2_waits", 128'(iss_valid), 128'(3'b000));
        fu_ready = 3'b111; step();
        check("par_fu2_late", 128'(iss_valid), 128'(3'b100));

        // Flush with simultaneous dispatch, then reset mid-operation
        fu_ready = '0;
        for (int i = 0; i < 5; i++) begin disp(i % 3, 0, 1, 6'(20 + i), 6'd0); step(); end
        disp(0, 1, 1, 6'd0, 6'd0); flush = 1; step(); idle();
        check("flush_count", 128'(count), 128'(0));
        check("flush_iss_valid", 128'(iss_valid), 128'(0));
        fu_ready = 3'b111;
        cdb_valid = 2'b11; cdb_tag = {6'd21, 6'd20}; step(); idle();
        for (int i = 0; i < 3; i++) step();
        fu_ready = '0;
        for (int i = 0; i < 5; i++) begin disp(i % 3, 1, 1, 6'd0, 6'd0); step(); end
        disp(1, 1, 1, 6'd0, 6'd0); rst = 1; fu_ready = 3'b111; step(); idle();
        check("rst_mid_count", 128'(count), 128'(0));
        check("rst_mid_iss_valid", 128'(iss_valid), 128'(0));
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            idle();
            if ($urandom_range(99) < 60)
                disp($urandom_range(2), $urandom_range(1), $urandom_range(1),
                     6'($urandom_range(7)), 6'($urandom_range(7)));
            cdb_valid = 2'($urandom);
            cdb_tag = {6'($urandom_range(7)), 6'($urandom_range(7))};
            cdb_data = {$urandom, $urandom};
            fu_ready = 3'($urandom);
            flush = ($urandom_range(99) == 0);
            rst = ($urandom_range(399) == 0);
            step();
        end

        // Drain: wake every tag and keep all FUs ready, bounded
        idle(); fu_ready = 3'b111; done = 0;
        for (int c = 0; c < 600 && !done; c++) begin
            cdb_valid = 2'b11;
            cdb_tag = {6'((2 * c + 1) % 8), 6'((2 * c) % 8)};
            cdb_data = {$urandom, $urandom};
            step();
            done = (m_ops.size() == 0);
        end
        idle();
        for (int i = 0; i < 3; i++) step();
        check("drain_done", 128'(done), 128'(1));
        for (int f = 0; f < NFU; f++)
            check($sformatf("leftover_fu%0d", f), 128'(exp_q[f].size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rs_multi_issue.md
Name: rs_multi_issue

Overview:
- Parametrised successor of the single-table reservation station.
- Holds DEPTH dispatched micro-ops, captures operands from NUM_CDB result broadcast buses, and issues at most one ready entry per functional unit per cycle (oldest first).
- Sits between rename/dispatch and the FU array.
- Adds what the previous station lacked: reset, back-pressure, CDB wakeup, free-slot reuse, flush and an occupancy count.

Parameters:
- PREG_WIDTH, 6, physical register tag width
- ROB_WIDTH, 6, ROB index width
- DATA_WIDTH, 32, operand/immediate width
- DEPTH, 16, number of entries (power of 2, ≥2)
- NUM_FU, 3, functional units (issue ports); FU_W = max(1,$clog2(NUM_FU))
- NUM_CDB, 2, result broadcast buses

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry available (registered count < DEPTH)
- disp_opcode/disp_funct3/disp_csigs  in  7/3/7  decoded fields
- disp_imm  in  DATA_WIDTH  immediate
- disp_rd  in  PREG_WIDTH  destination tag
- disp_src1, disp_src2  in  PREG_WIDTH  source tags
- disp_data1, disp_data2  in  DATA_WIDTH  source values when ready
- disp_rdy1, disp_rdy2  in  1  source value valid
- disp_fu  in  FU_W  target FU index
- disp_rob  in  ROB_WIDTH  ROB index
- cdb_valid  in  NUM_CDB  broadcast valid per bus
- cdb_tag  in  NUM_CDB*PREG_WIDTH  broadcast tags, bus k at [k*PREG_WIDTH +: PREG_WIDTH]
- cdb_data  in  NUM_CDB*DATA_WIDTH  broadcast values
- fu_ready  in  NUM_FU  FU f accepts an op this cycle
- iss_valid  out  NUM_FU  registered issue valid per FU
- iss_opcode, iss_funct3, iss_csigs, iss_imm, iss_rd, iss_data1, iss_data2, iss_rob  out  NUM_FU×field width, flattened per FU as above
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: all entries invalid; age state cleared; iss_valid=0; all iss_* data=0; count=0; disp_ready=1. Reset beats flush and dispatch.
- Dispatch: accepted when disp_valid & disp_ready. Written into the lowest-index free slot, valid at the next edge. disp_valid with disp_ready=0 is ignored (the producer holds).
- disp_ready uses registered occupancy only. Same-cycle issues do not free space for that cycle's dispatch.
- Wakeup: for each valid entry and each not-ready source, a match of any cdb_valid bus on that source tag sets rdy and captures cdb_data at the edge.
- Dispatch bypass: a dispatched source with rdy=0 whose tag matches a CDB bus in the dispatch cycle is stored ready with that bus's data.
- Multiple buses matching one tag: the lowest bus index wins.
- Select (combinational on registered state): entry i is eligible for FU f when valid, rdy1, rdy2, fu==f and fu_ready[f]=1. Per FU, the oldest eligible entry is chosen.
- A CDB wakeup in cycle N makes an entry eligible no earlier than cycle N+1. There is no same-cycle wakeup-to-issue.
- Issue: the chosen entry's fields go to iss_*[f] and iss_valid[f]=1 at the next edge, and the entry is freed at that same edge. iss_valid is a one-cycle pulse per issued op.
- Latency: dispatch at edge E with both operands ready gives iss_valid earliest after edge E+1.
- Age ordering: DEPTH×DEPTH age matrix. On dispatch into slot k, older[j][k]=valid[j] and older[k][j]=0 for all j. Freed rows/columns are don't-care, masked by valid.
- Simultaneous issue of slot k and dispatch: dispatch never targets a slot freed in the same cycle.
- Flush: all entries invalid and iss_valid=0 at the next edge. Dispatch and CDB that cycle are dropped. count=0.
- count: +1 per accepted dispatch, −1 per issued op, both applied at the same edge. It never exceeds DEPTH and never underflows.
- No other outputs change on flush/reset except as stated.

Optional Feature:
- Macro RS_AGE_SELECT_EN.
- Defined: oldest-first select via the age matrix, as above.
- Undefined: the age matrix is not built; per FU the lowest-index eligible entry issues. All other behaviour is identical.

Test Plan:
- Reset, then dispatch 16 ops with ready operands all to FU0, fu_ready=3'b001 held → disp_ready=0 after 16th, count=16; one iss_valid[0] pulse per cycle; count reaches 0 after 16 issues.
- Dispatch op A to FU1 with src1=5 not ready; 3 cycles later cdb_valid=01, cdb_tag[0]=5, cdb_data=0xDEADBEEF → iss_valid[1] one cycle after the broadcast cycle (not same cycle), iss_data1[1]=0xDEADBEEF.
- Dispatch with src2=9 not ready in the same cycle as CDB bus1 tag 9 data 0x1234 → entry stored ready; issue after next edge with iss_data2=0x1234.
- With RS_AGE_SELECT_EN: fill slots 0..3, issue slots 1 and 2 (freed), dispatch B to slot 1 then C to slot 2, all waiting on tag 7, then wake → issue order 0, 3, B, C. Without the macro → order 0, B, C, 3.
- Three ready ops, one each to FU0/1/2, all fu_ready=1 → iss_valid=3'b111 in one cycle. With fu_ready[2]=0 → iss_valid=3'b011, and the FU2 op waits.
- Flush with 5 entries valid and a simultaneous dispatch → count=0, iss_valid=0 next cycle, no later issue of any flushed op; rst mid-operation gives the same result.
